bram_result_reader: RTL and testbench

- Downstream drain stage for the BRAM accessor.
- Once the accessor signals done, this block reads a programmed number of DWIDTH-bit result words from the result BRAM (port-B style, 1-cycle read latency).
- It emits the words in address order on a valid/ready stream.
- An internal FIFO absorbs read latency and backpressure, so no word is lost or duplicated.

---
 rtl/bram_result_reader_if.sv | 28 ++
 rtl/bram_result_reader.sv | 252 +++++++++++++++++++++++++
 tb/tb_bram_result_reader.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_result_reader_if.sv
// bram_result_reader_if: the word stream leaving the BRAM result drain stage.
// Latency: none. This file only groups wires.
// Backpressure: the sink holds m_ready_i low to stall. The source then holds m_valid_o and m_data_o.
//
// Signals:
//   m_valid_o  word available at the head of the drain FIFO
//   m_ready_i  sink accepts the word this cycle
//   m_data_o   head word
// Modports: master = drain stage (source), slave = downstream sink.
interface bram_result_reader_if #(
  parameter int DWIDTH = 64
);
  logic              m_valid_o;
  logic              m_ready_i;
  logic [DWIDTH-1:0] m_data_o;

  modport master (
    output m_valid_o,
    output m_data_o,
    input  m_ready_i
  );

  modport slave (
    input  m_valid_o,
    input  m_data_o,
    output m_ready_i
  );
endinterface

// File: rtl/bram_result_reader.sv
// bram_result_reader: drains a programmed number of words from the result BRAM onto a valid/ready stream.
// Latency: the first read issues 1 cycle after the start edge, and the first word is valid 3 cycles after it.
//   Throughput is 1 word/cycle.
// Backpressure: reads are throttled so that FIFO contents plus the in-flight read never exceed FIFO_DEPTH.
//
// Ports:
//   clk, reset_n              clock and asynchronous active-low reset
//   start_run_i, run_count_i  start pulse (accepted only in IDLE) and number of words to read
//   idle_o, run_o, done_o     status: IDLE, RUN/DRAIN, and a one-cycle DONE pulse
//   addr_o, ce_o, we_o, q_i   BRAM read port with 1-cycle read latency; we_o is tied low
//   strm                      output word stream (bram_result_reader_if.master)
//   checksum_o                XOR of every streamed word; present only when RESULT_CHECKSUM_EN is defined

// Small synchronous FIFO. The head is combinational from storage, so the head word stays put until it is popped.
// Latency: a word pushed in cycle N is visible at the head in cycle N+1.
// Backpressure: none internally. The caller must never push when full or pop when empty.
module bram_result_reader_fifo #(
  parameter int DWIDTH = 64,
  parameter int DEPTH  = 4,
  parameter int OW     = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_push,
  input  logic [DWIDTH-1:0] i_dat,
  input  logic              i_pop,
  output logic [OW-1:0]     o_occ,
  output logic [DWIDTH-1:0] o_head
);
  localparam int              PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]   PTR_LAST = PW'(DEPTH - 1);
  localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
  localparam logic [OW-1:0]   OCC_ONE  = OW'(1);

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [OW-1:0]     r_occ;

  // Storage is reset as well, so the head reads 0 out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_push) begin
      r_mem[r_wr_ptr] <= i_dat;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_ONE;
      end
      if (i_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_ONE;
      end
      case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + OCC_ONE;
        2'b01:   r_occ <= r_occ - OCC_ONE;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_occ  = r_occ;
  assign o_head = r_mem[r_rd_ptr];
endmodule

module bram_result_reader #(
  parameter int CNT_BIT    = 31,
  parameter int DWIDTH     = 64,
  parameter int AWIDTH     = 8,
  parameter int MEM_SIZE   = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start_run_i,
  input  logic [CNT_BIT-1:0]  run_count_i,
  output logic                idle_o,
  output logic                run_o,
  output logic                done_o,
  output logic [AWIDTH-1:0]   addr_o,
  output logic                ce_o,
  output logic                we_o,
  input  logic [DWIDTH-1:0]   q_i,
  bram_result_reader_if.master strm
`ifdef RESULT_CHECKSUM_EN
  ,
  output logic [DWIDTH-1:0]   checksum_o
`endif
);
  localparam int                OW        = $clog2(FIFO_DEPTH + 1);
  localparam logic [OW:0]       DEPTH_L   = (OW + 1)'(FIFO_DEPTH);
  localparam logic [CNT_BIT-1:0] CNT_ONE  = CNT_BIT'(1);
  localparam logic [AWIDTH-1:0] ADDR_LAST = AWIDTH'(MEM_SIZE - 1);
  localparam logic [AWIDTH-1:0] ADDR_ONE  = AWIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [CNT_BIT-1:0] r_count;
  logic [CNT_BIT-1:0] r_issued;
  logic [CNT_BIT-1:0] r_xfer;
  logic [AWIDTH-1:0]  r_addr;
  logic               r_inflight;

  logic               w_start;
  logic               w_ce;
  logic               w_pop;
  logic               w_last_issue;
  logic               w_last_xfer;
  logic [OW:0]        w_outstanding;
  logic [OW-1:0]      w_occ;
  logic [DWIDTH-1:0]  w_head;

  // A start is accepted only from IDLE. A pulse in any other state is ignored,
  // so a running count can never be reloaded.
  assign w_start = (r_state == S_IDLE) && start_run_i;

  // A read may issue only when both the word already queued and the word still
  // coming back from the BRAM will have a FIFO slot. This rules out overflow,
  // which lets the capture side push unconditionally.
  always_comb begin
    w_outstanding = {1'b0, w_occ} + {{OW{1'b0}}, r_inflight};
    w_ce          = (r_state == S_RUN) && (r_issued < r_count) && (w_outstanding < DEPTH_L);
    w_pop         = strm.m_valid_o && strm.m_ready_i;
    w_last_issue  = w_ce && ((r_issued + CNT_ONE) == r_count);
    w_last_xfer   = w_pop && ((r_xfer + CNT_ONE) == r_count);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_run_i) begin
          w_state_nxt = (run_count_i == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last_issue) begin
          w_state_nxt = S_DRAIN;
        end
      end
      // The last word is transferred here. DONE then follows the final
      // handshake by exactly one cycle.
      S_DRAIN: begin
        if (w_last_xfer) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Issue and transfer bookkeeping. The address is tracked separately from the
  // issue count, so wrapping at MEM_SIZE needs no modulo on the wide counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count  <= '0;
      r_issued <= '0;
      r_xfer   <= '0;
      r_addr   <= '0;
    end else if (w_start) begin
      r_count  <= run_count_i;
      r_issued <= '0;
      r_xfer   <= '0;
      r_addr   <= '0;
    end else begin
      if (w_ce) begin
        r_issued <= r_issued + CNT_ONE;
        r_addr   <= (r_addr == ADDR_LAST) ? '0 : r_addr + ADDR_ONE;
      end
      if (w_pop) begin
        r_xfer <= r_xfer + CNT_ONE;
      end
    end
  end

  // q_i carries the data one cycle after ce_o, so r_inflight marks the cycle in
  // which q_i is captured.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_ce;
    end
  end

  bram_result_reader_fifo #(
    .DWIDTH (DWIDTH),
    .DEPTH  (FIFO_DEPTH),
    .OW     (OW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (r_inflight),
    .i_dat   (q_i),
    .i_pop   (w_pop),
    .o_occ   (w_occ),
    .o_head  (w_head)
  );

`ifdef RESULT_CHECKSUM_EN
  logic [DWIDTH-1:0] r_csum;

  // Cleared when a start is accepted. It then holds through DONE and IDLE,
  // so software can read it after the run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_csum <= '0;
    end else if (w_start) begin
      r_csum <= '0;
    end else if (w_pop) begin
      r_csum <= r_csum ^ w_head;
    end
  end

  assign checksum_o = r_csum;
`endif

  assign idle_o         = (r_state == S_IDLE);
  assign run_o          = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done_o         = (r_state == S_DONE);
  assign addr_o         = r_addr;
  assign ce_o           = w_ce;
  assign we_o           = 1'b0;
  assign strm.m_valid_o = (w_occ != '0);
  assign strm.m_data_o  = w_head;
endmodule

// File: tb/tb_bram_result_reader.sv
`timescale 1ns/1ps
module tb_bram_result_reader;
  localparam int CNT_BIT    = 31;
  localparam int DWIDTH     = 64;
  localparam int AWIDTH     = 8;
  localparam int MEM_SIZE   = 256;
  localparam int FIFO_DEPTH = 4;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               start_run_i;
  logic [CNT_BIT-1:0] run_count_i;
  logic               idle_o, run_o, done_o, ce_o, we_o;
  logic [AWIDTH-1:0]  addr_o;
  logic [DWIDTH-1:0]  q_i;
`ifdef RESULT_CHECKSUM_EN
  logic [DWIDTH-1:0]  checksum_o;
`endif

  bram_result_reader_if #(.DWIDTH(DWIDTH)) s_if ();

  bram_result_reader #(
    .CNT_BIT(CNT_BIT), .DWIDTH(DWIDTH), .AWIDTH(AWIDTH),
    .MEM_SIZE(MEM_SIZE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_run_i (start_run_i),
    .run_count_i (run_count_i),
    .idle_o      (idle_o),
    .run_o       (run_o),
    .done_o      (done_o),
    .addr_o      (addr_o),
    .ce_o        (ce_o),
    .we_o        (we_o),
    .q_i         (q_i),
    .strm        (s_if)
`ifdef RESULT_CHECKSUM_EN
    ,
    .checksum_o  (checksum_o)
`endif
  );

  always #5 clk = ~clk;

  // BRAM model: 1-cycle read latency, and each word holds its address plus one.
  always @(posedge clk) begin
    if (ce_o) q_i <= DWIDTH'(addr_o) + 64'd1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and per-run statistics
  logic [DWIDTH-1:0] sb[$];
  int          exp_addr, prev_ce_addr;
  int          ce_cnt, hs_cnt, done_cnt;
  int          first_ce, last_ce, first_vld, last_hs, done_stamp;
  bit          saw_wrap, prev_stall;
  logic [63:0] prev_data, model_csum;

  // Monitor: sampled mid-cycle. stamp = index of the cycle following the last posedge.
  always @(negedge clk) begin
    int stamp;
    logic [DWIDTH-1:0] e;
    stamp = cyc + 1;
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (ce_o) begin
        chk("rd_addr", 64'(addr_o), 64'(exp_addr));
        if (prev_ce_addr == MEM_SIZE - 1 && addr_o == '0) saw_wrap = 1'b1;
        prev_ce_addr = int'(addr_o);
        sb.push_back(DWIDTH'(exp_addr) + 64'd1);
        exp_addr = (exp_addr + 1) % MEM_SIZE;
        if (first_ce < 0) first_ce = stamp;
        last_ce = stamp;
        ce_cnt++;
      end
      if (prev_stall) begin
        chk("stall_vld", 64'(s_if.m_valid_o), 64'd1);
        chk("stall_dat", s_if.m_data_o, prev_data);
      end
      if (s_if.m_valid_o && first_vld < 0) first_vld = stamp;
      if (s_if.m_valid_o && s_if.m_ready_i) begin
        if (sb.size() == 0) begin
          chk("sb_nonempty", 64'd0, 64'd1);
        end else begin
          e = sb.pop_front();
          chk("stream_dat", s_if.m_data_o, e);
          model_csum = model_csum ^ e;
        end
        hs_cnt++;
        last_hs = stamp;
      end
      prev_stall = s_if.m_valid_o && !s_if.m_ready_i;
      prev_data  = s_if.m_data_o;
      if (done_o) begin
        done_cnt++;
        done_stamp = stamp;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int t0;

  task automatic clr_stats();
    sb.delete();
    exp_addr = 0; prev_ce_addr = -1;
    ce_cnt = 0; hs_cnt = 0; done_cnt = 0;
    first_ce = -1; last_ce = -1; first_vld = -1; last_hs = -1; done_stamp = -1;
    saw_wrap = 1'b0;
    model_csum = '0;
  endtask

  // Called at posedge+1. Returns in cycle T+1, where T is the start edge.
  task automatic start_run(input int c);
    clr_stats();
    start_run_i = 1'b1;
    run_count_i = CNT_BIT'(c);
    @(posedge clk);
    #1;
    t0 = cyc;
    start_run_i = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int n;
    int d0;
    n  = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && n < max_cyc) begin
      tick();
      n++;
    end
    chk("done_seen", 64'(done_cnt != d0), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int d0;
    reset_n = 1'b0;
    start_run_i = 1'b0;
    run_count_i = '0;
    s_if.m_ready_i = 1'b1;
    clr_stats();
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    chk("rst_idle", 64'(idle_o), 64'd1);
    chk("rst_run", 64'(run_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_ce", 64'(ce_o), 64'd0);
    chk("rst_we", 64'(we_o), 64'd0);
    chk("rst_vld", 64'(s_if.m_valid_o), 64'd0);
    chk("rst_addr", 64'(addr_o), 64'd0);
    chk("rst_dat", s_if.m_data_o, 64'd0);
`ifdef RESULT_CHECKSUM_EN
    chk("rst_csum", checksum_o, 64'd0);
`endif
    reset_n = 1'b1;
    tick();

    // Count 4 with a free-running sink
    start_run(4);
    chk("t1_run", 64'(run_o), 64'd1);
    chk("t1_idle", 64'(idle_o), 64'd0);
    wait_done(40);
    chk("t1_first_ce", 64'(first_ce), 64'(t0 + 1));
    chk("t1_last_ce", 64'(last_ce), 64'(t0 + 4));
    chk("t1_ce_cnt", 64'(ce_cnt), 64'd4);
    chk("t1_first_vld", 64'(first_vld), 64'(t0 + 3));
    chk("t1_last_hs", 64'(last_hs), 64'(t0 + 6));
    chk("t1_hs_cnt", 64'(hs_cnt), 64'd4);
    chk("t1_done_at", 64'(done_stamp), 64'(t0 + 7));
    chk("t1_done_cnt", 64'(done_cnt), 64'd1);
    chk("t1_idle_at", 64'(cyc + 1), 64'(t0 + 8));
    chk("t1_idle_back", 64'(idle_o), 64'd1);
    chk("t1_sb_empty", 64'(sb.size()), 64'd0);
`ifdef RESULT_CHECKSUM_EN
    chk("t1_csum", checksum_o, 64'd4);
    chk("t1_csum_model", checksum_o, model_csum);
`endif
    tick();
`ifdef RESULT_CHECKSUM_EN
    chk("t1_csum_held", checksum_o, 64'd4);
`endif

    // Count 8 with the sink stalled in cycles T+3..T+10
    s_if.m_ready_i = 1'b0;
    start_run(8);
`ifdef RESULT_CHECKSUM_EN
    chk("t2_csum_clr", checksum_o, 64'd0);
`endif
    repeat (9) tick();
    chk("t2_ce_stalled", 64'(ce_cnt), 64'(FIFO_DEPTH));
    chk("t2_vld_stalled", 64'(s_if.m_valid_o), 64'd1);
    chk("t2_dat_stalled", s_if.m_data_o, 64'd1);
    chk("t2_hs_stalled", 64'(hs_cnt), 64'd0);
    tick();
    s_if.m_ready_i = 1'b1;
    wait_done(60);
    chk("t2_hs_cnt", 64'(hs_cnt), 64'd8);
    chk("t2_ce_cnt", 64'(ce_cnt), 64'd8);
    chk("t2_done_cnt", 64'(done_cnt), 64'd1);
    chk("t2_sb_empty", 64'(sb.size()), 64'd0);
    tick();

    // Count 0: immediate done pulse
    start_run(0);
    chk("t3_done", 64'(done_o), 64'd1);
    chk("t3_ce", 64'(ce_o), 64'd0);
    tick();
    chk("t3_done_drop", 64'(done_o), 64'd0);
    chk("t3_idle", 64'(idle_o), 64'd1);
    repeat (3) tick();
    chk("t3_ce_cnt", 64'(ce_cnt), 64'd0);
    chk("t3_no_vld", 64'(first_vld), 64'hffff_ffff_ffff_ffff);
    chk("t3_done_cnt", 64'(done_cnt), 64'd1);

    // Count 300: address wrap, plus an ignored start mid-run
    start_run(300);
    repeat (50) tick();
    start_run_i = 1'b1;
    run_count_i = CNT_BIT'(5);
    tick();
    start_run_i = 1'b0;
    wait_done(400);
    chk("t4_hs_cnt", 64'(hs_cnt), 64'd300);
    chk("t4_ce_cnt", 64'(ce_cnt), 64'd300);
    chk("t4_done_cnt", 64'(done_cnt), 64'd1);
    chk("t4_wrap", 64'(saw_wrap), 64'd1);
    chk("t4_sb_empty", 64'(sb.size()), 64'd0);
    tick();

    // Count 16 with reset after the 5th handshake, then restart with count 2
    start_run(16);
    n = 0;
    while (hs_cnt < 5 && n < 50) begin
      tick();
      n++;
    end
    chk("t5_reach5", 64'(hs_cnt), 64'd5);
    d0 = done_cnt;
    reset_n = 1'b0;
    #1;
    chk("t5_idle", 64'(idle_o), 64'd1);
    chk("t5_run", 64'(run_o), 64'd0);
    chk("t5_done", 64'(done_o), 64'd0);
    chk("t5_ce", 64'(ce_o), 64'd0);
    chk("t5_vld", 64'(s_if.m_valid_o), 64'd0);
    chk("t5_addr", 64'(addr_o), 64'd0);
    chk("t5_dat", s_if.m_data_o, 64'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (2) tick();
    chk("t5_no_done", 64'(done_cnt), 64'(d0));
    chk("t5_idle_after", 64'(idle_o), 64'd1);
    start_run(2);
    wait_done(40);
    chk("t5_first_ce", 64'(first_ce), 64'(t0 + 1));
    chk("t5_ce_cnt", 64'(ce_cnt), 64'd2);
    chk("t5_hs_cnt", 64'(hs_cnt), 64'd2);
    chk("t5_done_cnt", 64'(done_cnt), 64'd1);
    chk("t5_sb_empty", 64'(sb.size()), 64'd0);
`ifdef RESULT_CHECKSUM_EN
    chk("t5_csum", checksum_o, 64'd3);
`endif
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
